ps2_note_decoder: RTL

- Upstream stage of the 7-segment note display.
- Receives PS/2 set-2 scancodes from the keyboard, tracks make/break/extended prefixes, and maintains a current octave (3..5).
- Drives the 6-bit note code that the display and tone-generator stages consume.
- The note code uses the display encoding, including the out-of-order F#3 = 35 and stop = 63.

---
 rtl/ps2_note_decoder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_note_decoder.sv
// ============================================================================
// ps2_note_decoder
//   Receives PS/2 set-2 scancodes, tracks make/break/extended prefixes,
//   keeps the current octave (3..5) and drives the 6-bit display note code.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module ps2_note_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int DEFAULT_OCTAVE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [5:0] note,
  output logic       key_down,
  output logic [2:0] octave,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam int         WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [5:0] NOTE_STOP  = 6'h3F;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_OCT_DN = 8'h1A;
  localparam logic [7:0] CODE_OCT_UP = 8'h22;

  // --------------------------------------------------------------------------
  // Input synchronizers and falling-edge detect
  // --------------------------------------------------------------------------
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  // Two-flop synchronizers; lines idle high so reset to 1 to avoid a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // --------------------------------------------------------------------------
  // Frame receiver with watchdog
  // --------------------------------------------------------------------------
  logic [3:0]      bit_cnt;
  logic [9:0]      shreg;     // [0]=start, [8:1]=data, [9]=parity
  logic [WD_W-1:0] wd_cnt;
  logic            frame_good;

  // Stop bit is the data sampled on the 11th edge itself
  assign frame_good = (shreg[0] == 1'b0) && (data_s2 == 1'b1) && (^shreg[9:1] == 1'b1);

  // Shift in bits on each falling edge, validate on the 11th, abort on timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt    <= 4'd0;
      shreg      <= 10'd0;
      wd_cnt     <= '0;
      scan_valid <= 1'b0;
      scan_code  <= 8'h00;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (fall) begin
        // An edge always wins over a coincident timeout
        wd_cnt <= '0;
        if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
          if (frame_good) begin
            scan_code  <= shreg[8:1];
            scan_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
        end else begin
          shreg[bit_cnt] <= data_s2;
          bit_cnt        <= bit_cnt + 4'd1;
        end
      end else if (bit_cnt != 4'd0) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          bit_cnt   <= 4'd0;
          wd_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Key mapping helpers
  // --------------------------------------------------------------------------

  // Returns {is_semitone, s[3:0]}
  function automatic logic [4:0] semitone_of(input logic [7:0] code);
    logic [4:0] r;
    r = 5'd0;
    case (code)
      8'h1C: r = {1'b1, 4'd0};
      8'h1D: r = {1'b1, 4'd1};
      8'h1B: r = {1'b1, 4'd2};
      8'h24: r = {1'b1, 4'd3};
      8'h23: r = {1'b1, 4'd4};
      8'h2B: r = {1'b1, 4'd5};
      8'h2C: r = {1'b1, 4'd6};
      8'h34: r = {1'b1, 4'd7};
      8'h35: r = {1'b1, 4'd8};
      8'h33: r = {1'b1, 4'd9};
      8'h3C: r = {1'b1, 4'd10};
      8'h3B: r = {1'b1, 4'd11};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Display encoding: octave 3 places F#3 out of order at 35
  function automatic logic [5:0] note_code(input logic [2:0] oct, input logic [3:0] s);
    logic [5:0] r;
    r = 6'd0;
    case (oct)
      3'd3: begin
        if (s < 4'd6)       r = {2'b00, s};
        else if (s == 4'd6) r = 6'd35;
        else                r = {2'b00, s} - 6'd1;
      end
      3'd4:    r = 6'd11 + {2'b00, s};
      default: r = 6'd23 + {2'b00, s};
    endcase
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Decode FSM
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } state_t;

  state_t     state, state_n;
  logic [5:0] note_n;
  logic       key_down_n;
  logic [2:0] octave_n;
  logic [3:0] held_s, held_s_n;
  logic [4:0] semi;

  assign semi = semitone_of(scan_code);

  // State and note registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      note     <= NOTE_STOP;
      key_down <= 1'b0;
      octave   <= 3'(DEFAULT_OCTAVE);
      held_s   <= 4'd0;
    end else begin
      state    <= state_n;
      note     <= note_n;
      key_down <= key_down_n;
      octave   <= octave_n;
      held_s   <= held_s_n;
    end
  end

  // Next-state and make/break actions, evaluated only on a received byte
  always_comb begin
    state_n    = state;
    note_n     = note;
    key_down_n = key_down;
    octave_n   = octave;
    held_s_n   = held_s;
    if (scan_valid) begin
      case (state)
        S_IDLE: begin
          if (scan_code == CODE_EXT) begin
            state_n = S_EXT;
          end else if (scan_code == CODE_BREAK) begin
            state_n = S_BREAK;
          end else if (semi[4]) begin
            note_n     = note_code(octave, semi[3:0]);
            key_down_n = 1'b1;
            held_s_n   = semi[3:0];
          end else if (scan_code == CODE_OCT_DN) begin
            if (octave > 3'd3) octave_n = octave - 3'd1;
          end else if (scan_code == CODE_OCT_UP) begin
            if (octave < 3'd5) octave_n = octave + 3'd1;
          end
        end
        S_BREAK: begin
          state_n = S_IDLE;
          // Only releasing the most recently pressed key silences the note
          if (semi[4] && (semi[3:0] == held_s) && key_down) begin
            note_n     = NOTE_STOP;
            key_down_n = 1'b0;
          end
        end
        S_EXT: begin
          state_n = (scan_code == CODE_BREAK) ? S_EXT_BREAK : S_IDLE;
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
